// File: rtl/ll_fifo_pkg.sv
// Width helpers and queue-id helpers shared by the linked-list FIFO scheduler.
package ll_fifo_pkg;

   typedef int unsigned qid_t;

   function automatic int ptr_w(input int depth);
      return $clog2(depth);
   endfunction

   function automatic int sel_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // An occupancy counter must hold the value DEPTH itself.
   function automatic int occ_w(input int depth);
      return ptr_w(depth) + 1;
   endfunction

   function automatic qid_t next_qid(input qid_t q, input qid_t n);
      return (q + 1) % n;
   endfunction

endpackage

// File: rtl/ll_fifo_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter
   import ll_fifo_pkg::*;
#(
   parameter  int N  = 2,
   localparam int IW = sel_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx
);

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      for (int i = 0; i < N; i++) begin
         if (gnt == '0 && req[(int'(ptr) + i) % N]) begin
            gnt[(int'(ptr) + i) % N] = 1'b1;
            gnt_idx                  = IW'((int'(ptr) + i) % N);
         end
      end
   end

endmodule

// File: rtl/ll_fifo_sched.sv
// Push/pop scheduler for the shared linked-list FIFO: quota-limited RR push, RR pop.
// Define LL_FIFO_SCHED_STRICT_Q0_EN to give queue 0 strict priority on the pop side.
module ll_fifo_sched
   import ll_fifo_pkg::*;
#(
   parameter  int WIDTH     = 4,
   parameter  int DEPTH     = 2,
   parameter  int NUM_FIFOS = 2,
   parameter  int QUOTA     = DEPTH,
   localparam int SEL_WIDTH = sel_w(NUM_FIFOS),
   localparam int OCC_W     = occ_w(DEPTH)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_FIFOS-1:0]       enq_vld,
   input  logic [NUM_FIFOS*WIDTH-1:0] enq_data,
   output logic [NUM_FIFOS-1:0]       enq_rdy,
   input  logic [NUM_FIFOS-1:0]       deq_rdy,
   output logic                       out_vld,
   output logic [SEL_WIDTH-1:0]       out_qid,
   output logic [WIDTH-1:0]           out_data,
   output logic                       fifo_push,
   output logic [SEL_WIDTH-1:0]       fifo_push_sel,
   output logic [WIDTH-1:0]           fifo_data_in,
   output logic                       fifo_pop,
   output logic [SEL_WIDTH-1:0]       fifo_pop_sel,
   input  logic                       fifo_full,
   input  logic [WIDTH-1:0]           fifo_data_out,
   output logic [NUM_FIFOS*OCC_W-1:0] occ
);

   logic [NUM_FIFOS-1:0][OCC_W-1:0] occ_q, occ_d;
   logic [SEL_WIDTH-1:0] push_rr_q, push_rr_d, pop_rr_q, pop_rr_d;
   logic                 out_vld_q;
   logic [SEL_WIDTH-1:0] out_qid_q;
   logic [WIDTH-1:0]     out_data_q;

   logic [NUM_FIFOS-1:0] push_elig, pop_elig, push_gnt, pop_rr_gnt, pop_gnt;
   logic [SEL_WIDTH-1:0] push_idx, pop_rr_idx, pop_idx;
   logic                 pop_adv;

   // Pop looks only at registered occupancy, so a word is never popped in its push cycle.
   always_comb begin
      push_elig = '0;
      pop_elig  = '0;
      for (int q = 0; q < NUM_FIFOS; q++) begin
         push_elig[q] = enq_vld[q] & ~fifo_full & (occ_q[q] < OCC_W'(QUOTA));
         pop_elig[q]  = deq_rdy[q] & (occ_q[q] != '0);
      end
   end

   rr_arbiter #(.N(NUM_FIFOS)) u_push_arb (
      .req(push_elig), .ptr(push_rr_q), .gnt(push_gnt), .gnt_idx(push_idx)
   );

   rr_arbiter #(.N(NUM_FIFOS)) u_pop_arb (
      .req(pop_elig), .ptr(pop_rr_q), .gnt(pop_rr_gnt), .gnt_idx(pop_rr_idx)
   );

`ifdef LL_FIFO_SCHED_STRICT_Q0_EN
   // Queue 0 overrides the pop RR and leaves its pointer untouched.
   always_comb begin
      pop_gnt = pop_rr_gnt;
      pop_idx = pop_rr_idx;
      pop_adv = |pop_rr_gnt;
      if (pop_elig[0]) begin
         pop_gnt = NUM_FIFOS'(1);
         pop_idx = '0;
         pop_adv = 1'b0;
      end
   end
`else
   assign pop_gnt = pop_rr_gnt;
   assign pop_idx = pop_rr_idx;
   assign pop_adv = |pop_rr_gnt;
`endif

   assign enq_rdy       = push_gnt;
   assign fifo_push     = |push_gnt;
   assign fifo_push_sel = push_idx;
   assign fifo_data_in  = enq_data[int'(push_idx)*WIDTH +: WIDTH];
   assign fifo_pop      = |pop_gnt;
   assign fifo_pop_sel  = pop_idx;

   always_comb begin
      push_rr_d = push_rr_q;
      pop_rr_d  = pop_rr_q;
      if (fifo_push) push_rr_d = SEL_WIDTH'(next_qid(qid_t'(push_idx), qid_t'(NUM_FIFOS)));
      if (pop_adv)   pop_rr_d  = SEL_WIDTH'(next_qid(qid_t'(pop_idx), qid_t'(NUM_FIFOS)));
      for (int q = 0; q < NUM_FIFOS; q++)
         occ_d[q] = occ_q[q] + OCC_W'(push_gnt[q]) - OCC_W'(pop_gnt[q]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         occ_q      <= '0;
         push_rr_q  <= '0;
         pop_rr_q   <= '0;
         out_vld_q  <= 1'b0;
         out_qid_q  <= '0;
         out_data_q <= '0;
      end else begin
         occ_q     <= occ_d;
         push_rr_q <= push_rr_d;
         pop_rr_q  <= pop_rr_d;
         out_vld_q <= fifo_pop;
         if (fifo_pop) begin
            out_qid_q  <= pop_idx;
            out_data_q <= fifo_data_out;
         end
      end
   end

   assign out_vld  = out_vld_q;
   assign out_qid  = out_qid_q;
   assign out_data = out_data_q;
   assign occ      = occ_q;

endmodule

// File: tb/tb_ll_fifo_sched.sv
// Bench for ll_fifo_sched: vector table, corner sequences and a random run against a queue model.
module tb_ll_fifo_sched;

   localparam int WIDTH = 4, DEPTH = 4, NF = 2, QUOTA = 3, OW = 3, SW = 1;

   logic                clk = 1'b0, rst = 1'b1;
   logic [NF-1:0]       enq_vld = '0, deq_rdy = '0, enq_rdy;
   logic [NF*WIDTH-1:0] enq_data = '0;
   logic                out_vld, fifo_push, fifo_pop, fifo_full;
   logic [SW-1:0]       out_qid, fifo_push_sel, fifo_pop_sel;
   logic [WIDTH-1:0]    out_data, fifo_data_in, fifo_data_out;
   logic [NF*OW-1:0]    occ;
   int n_chk = 0, n_err = 0;

   always #5 clk = ~clk;

   ll_fifo_sched #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_FIFOS(NF), .QUOTA(QUOTA)) dut (
      .clk(clk), .rst(rst), .enq_vld(enq_vld), .enq_data(enq_data), .enq_rdy(enq_rdy),
      .deq_rdy(deq_rdy), .out_vld(out_vld), .out_qid(out_qid), .out_data(out_data),
      .fifo_push(fifo_push), .fifo_push_sel(fifo_push_sel), .fifo_data_in(fifo_data_in),
      .fifo_pop(fifo_pop), .fifo_pop_sel(fifo_pop_sel), .fifo_full(fifo_full),
      .fifo_data_out(fifo_data_out), .occ(occ)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Environment: the shared FIFO itself, as per-queue word queues.
   logic [WIDTH-1:0] envq [NF][$];
   logic [WIDTH-1:0] env_head [NF] = '{default: '0};
   logic             env_full = 1'b0;
   logic             l_push, l_pop;
   logic [SW-1:0]    l_psel, l_osel;
   logic [WIDTH-1:0] l_din;

   assign fifo_full     = env_full;
   assign fifo_data_out = env_head[fifo_pop_sel];

   always @(negedge clk) begin
      l_push = fifo_push; l_psel = fifo_push_sel; l_din = fifo_data_in;
      l_pop  = fifo_pop;  l_osel = fifo_pop_sel;
   end

   always @(posedge clk) begin
      if (rst) begin
         for (int q = 0; q < NF; q++) envq[q].delete();
      end else begin
         if (l_pop === 1'b1 && envq[l_osel].size() > 0) void'(envq[l_osel].pop_front());
         if (l_push === 1'b1) envq[l_psel].push_back(l_din);
      end
      for (int q = 0; q < NF; q++) env_head[q] <= (envq[q].size() > 0) ? envq[q][0] : '0;
      env_full <= (envq[0].size() + envq[1].size()) == DEPTH;
   end

   // Reference model: counts, RR pointers and expected per-queue contents.
   int               m_occ [NF];
   int               m_prr, m_orr, m_oqid;
   bit               m_ovld;
   logic [WIDTH-1:0] m_odata;
   logic [WIDTH-1:0] mq [NF][$];

   function automatic int rr_pick(input logic [NF-1:0] el, input int start);
      for (int i = 0; i < NF; i++) if (el[(start + i) % NF]) return (start + i) % NF;
      return -1;
   endfunction

   always @(negedge clk) begin : model
      int gp, gq, tot;
      bit strict;
      logic [NF-1:0] pe, oe;
      if (rst) begin
         for (int q = 0; q < NF; q++) begin m_occ[q] = 0; mq[q].delete(); end
         m_prr = 0; m_orr = 0; m_ovld = 0; m_oqid = 0; m_odata = '0;
      end else begin
         tot = m_occ[0] + m_occ[1];
         for (int q = 0; q < NF; q++) begin
            pe[q] = enq_vld[q] && tot < DEPTH && m_occ[q] < QUOTA;
            oe[q] = deq_rdy[q] && m_occ[q] > 0;
         end
         gp = rr_pick(pe, m_prr);
         strict = 1'b0;
`ifdef LL_FIFO_SCHED_STRICT_Q0_EN
         strict = oe[0];
`endif
         gq = strict ? 0 : rr_pick(oe, m_orr);
         chk("m_enq_rdy", enq_rdy, (gp < 0) ? 0 : (1 << gp));
         chk("m_push", fifo_push, gp >= 0);
         if (gp >= 0) begin
            chk("m_push_sel", fifo_push_sel, gp);
            chk("m_data_in", fifo_data_in, enq_data[gp*WIDTH +: WIDTH]);
         end
         chk("m_pop", fifo_pop, gq >= 0);
         if (gq >= 0) chk("m_pop_sel", fifo_pop_sel, gq);
         for (int q = 0; q < NF; q++) chk("m_occ", occ[q*OW +: OW], m_occ[q]);
         chk("m_full", fifo_full, tot == DEPTH);
         chk("m_out_vld", out_vld, m_ovld);
         if (m_ovld) begin
            chk("m_out_qid", out_qid, m_oqid);
            chk("m_out_data", out_data, m_odata);
         end
         m_ovld = gq >= 0;
         if (gq >= 0) begin
            m_oqid = gq; m_odata = mq[gq].pop_front(); m_occ[gq]--;
            if (!strict) m_orr = (gq + 1) % NF;
         end
         if (gp >= 0) begin
            mq[gp].push_back(enq_data[gp*WIDTH +: WIDTH]); m_occ[gp]++;
            m_prr = (gp + 1) % NF;
         end
      end
   end

   typedef struct {
      logic [1:0] vld; logic [7:0] data; logic [1:0] deq;
      logic [1:0] rdy; logic [5:0] occ; logic full; logic pop; logic psel;
      logic ovld; logic oqid; logic [3:0] odata;
   } vec_t;
   vec_t tv [21];
   int   exp6 [4];

   task automatic do_reset();
      @(posedge clk); #1; rst = 1'b1; enq_vld = '0; deq_rdy = '0;
      @(posedge clk); #1; rst = 1'b0;
   endtask

   task automatic drive(input logic [1:0] v, input logic [7:0] d, input logic [1:0] r);
      @(posedge clk); #1; enq_vld = v; enq_data = d; deq_rdy = r;
      @(negedge clk);
   endtask

   initial begin
      // occ column is octal {occ1,occ0}
      tv[0]  = '{2'b11, 8'h5A, 2'b00, 2'b00 | 2'b01, 6'o00, 0, 0, 0, 0, 0, 4'h0};
      tv[1]  = '{2'b11, 8'h5A, 2'b00, 2'b10, 6'o01, 0, 0, 0, 0, 0, 4'h0};
      tv[2]  = '{2'b11, 8'h5A, 2'b00, 2'b01, 6'o11, 0, 0, 0, 0, 0, 4'h0};
      tv[3]  = '{2'b11, 8'h5A, 2'b00, 2'b10, 6'o12, 0, 0, 0, 0, 0, 4'h0};
      tv[4]  = '{2'b11, 8'h5A, 2'b00, 2'b00, 6'o22, 1, 0, 0, 0, 0, 4'h0};
      tv[5]  = '{2'b11, 8'h5A, 2'b00, 2'b00, 6'o22, 1, 0, 0, 0, 0, 4'h0};
      tv[6]  = '{2'b00, 8'h00, 2'b11, 2'b00, 6'o22, 1, 1, 0, 0, 0, 4'h0};
`ifdef LL_FIFO_SCHED_STRICT_Q0_EN
      tv[7]  = '{2'b00, 8'h00, 2'b11, 2'b00, 6'o21, 0, 1, 0, 1, 0, 4'hA};
      tv[8]  = '{2'b00, 8'h00, 2'b11, 2'b00, 6'o20, 0, 1, 1, 1, 0, 4'hA};
      tv[9]  = '{2'b00, 8'h00, 2'b11, 2'b00, 6'o10, 0, 1, 1, 1, 1, 4'h5};
      exp6   = '{0, 0, 0, 1};
`else
      tv[7]  = '{2'b00, 8'h00, 2'b11, 2'b00, 6'o21, 0, 1, 1, 1, 0, 4'hA};
      tv[8]  = '{2'b00, 8'h00, 2'b11, 2'b00, 6'o11, 0, 1, 0, 1, 1, 4'h5};
      tv[9]  = '{2'b00, 8'h00, 2'b11, 2'b00, 6'o10, 0, 1, 1, 1, 0, 4'hA};
      exp6   = '{0, 1, 0, 0};
`endif
      tv[10] = '{2'b00, 8'h00, 2'b11, 2'b00, 6'o00, 0, 0, 0, 1, 1, 4'h5};
      tv[11] = '{2'b00, 8'h00, 2'b00, 2'b00, 6'o00, 0, 0, 0, 0, 0, 4'h0};
      tv[12] = '{2'b01, 8'h01, 2'b00, 2'b01, 6'o00, 0, 0, 0, 0, 0, 4'h0};
      tv[13] = '{2'b01, 8'h02, 2'b00, 2'b01, 6'o01, 0, 0, 0, 0, 0, 4'h0};
      tv[14] = '{2'b01, 8'h03, 2'b00, 2'b01, 6'o02, 0, 0, 0, 0, 0, 4'h0};
      tv[15] = '{2'b01, 8'h04, 2'b00, 2'b00, 6'o03, 0, 0, 0, 0, 0, 4'h0};
      tv[16] = '{2'b11, 8'h74, 2'b00, 2'b10, 6'o03, 0, 0, 0, 0, 0, 4'h0};
      tv[17] = '{2'b00, 8'h00, 2'b01, 2'b00, 6'o13, 1, 1, 0, 0, 0, 4'h0};
      tv[18] = '{2'b00, 8'h00, 2'b01, 2'b00, 6'o12, 0, 1, 0, 1, 0, 4'h1};
      tv[19] = '{2'b00, 8'h00, 2'b00, 2'b00, 6'o11, 0, 0, 0, 1, 0, 4'h2};
      tv[20] = '{2'b00, 8'h00, 2'b00, 2'b00, 6'o11, 0, 0, 0, 0, 0, 4'h0};

      do_reset();
      @(negedge clk);
      chk("rst_occ", occ, 0); chk("rst_out_vld", out_vld, 0);
      chk("rst_out_qid", out_qid, 0); chk("rst_out_data", out_data, 0);

      foreach (tv[i]) begin
         drive(tv[i].vld, tv[i].data, tv[i].deq);
         chk($sformatf("t%0d_rdy", i), enq_rdy, tv[i].rdy);
         chk($sformatf("t%0d_occ", i), occ, tv[i].occ);
         chk($sformatf("t%0d_full", i), fifo_full, tv[i].full);
         chk($sformatf("t%0d_pop", i), fifo_pop, tv[i].pop);
         if (tv[i].pop) chk($sformatf("t%0d_psel", i), fifo_pop_sel, tv[i].psel);
         chk($sformatf("t%0d_ovld", i), out_vld, tv[i].ovld);
         if (tv[i].ovld) begin
            chk($sformatf("t%0d_oqid", i), out_qid, tv[i].oqid);
            chk($sformatf("t%0d_odata", i), out_data, tv[i].odata);
         end
      end

      // Push into empty q1 while its consumer is ready: pop only next cycle.
      do_reset();
      drive(2'b10, 8'hC0, 2'b10);
      chk("same_rdy", enq_rdy, 2'b10); chk("same_nopop", fifo_pop, 0);
      drive(2'b00, 8'h00, 2'b10);
      chk("same_pop", fifo_pop, 1); chk("same_psel", fifo_pop_sel, 1);
      drive(2'b00, 8'h00, 2'b00);
      chk("same_ovld", out_vld, 1); chk("same_qid", out_qid, 1); chk("same_data", out_data, 4'hC);

      // Full FIFO with a pop: push waits one cycle.
      do_reset();
      @(posedge clk); #1; enq_vld = 2'b11; enq_data = 8'h36;
      repeat (4) @(posedge clk);
      #1; enq_vld = 2'b01; enq_data = 8'h09; deq_rdy = 2'b01;
      @(negedge clk);
      chk("full_full", fifo_full, 1); chk("full_rdy", enq_rdy, 0); chk("full_pop", fifo_pop, 1);
      drive(2'b01, 8'h09, 2'b00);
      chk("full_nfull", fifo_full, 0); chk("full_rdy2", enq_rdy, 2'b01); chk("full_occ", occ, 6'o21);
      drive(2'b00, 8'h00, 2'b00);
      chk("full_occ2", occ, 6'o22); chk("full_full2", fifo_full, 1);

      // Reset in the middle of a pop burst drops the pending output.
      drive(2'b00, 8'h00, 2'b11);
      chk("mid_pop", fifo_pop, 1);
      @(posedge clk); #1; rst = 1'b1;
      @(negedge clk); chk("mid_pend", out_vld, 1);
      @(posedge clk); #1; rst = 1'b0; deq_rdy = '0;
      @(negedge clk); chk("mid_ovld", out_vld, 0); chk("mid_occ", occ, 0);

      // Pop order with q0 heavier than q1.
      do_reset();
      drive(2'b01, 8'h01, 2'b00); drive(2'b01, 8'h02, 2'b00);
      drive(2'b01, 8'h03, 2'b00); drive(2'b10, 8'h80, 2'b00);
      for (int k = 0; k < 4; k++) begin
         drive(2'b00, 8'h00, 2'b11);
         chk($sformatf("prio%0d_pop", k), fifo_pop, 1);
         chk($sformatf("prio%0d_sel", k), fifo_pop_sel, exp6[k]);
      end

      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         rst      = ($urandom_range(0, 249) == 0);
         enq_vld  = NF'($urandom);
         enq_data = (NF*WIDTH)'($urandom);
         deq_rdy  = ((i % 400) < 200) ? NF'($urandom & $urandom & $urandom) : NF'($urandom);
      end
      @(posedge clk); #1; rst = 1'b0; enq_vld = '0; deq_rdy = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/ll_fifo_sched.md
Name: ll_fifo_sched

Overview:
Push/pop scheduler that sits in front of the shared linked-list FIFO (NUM_FIFOS logical queues in DEPTH shared entries). Each cycle it:
- arbitrates N producers onto the single push port, round-robin, with a per-queue occupancy quota so one queue cannot starve the others of shared storage;
- arbitrates N consumers onto the single pop port, round-robin.
It drives the FIFO's push/pop/push_sel/pop_sel/data_in, and returns popped data with its queue id.

Parameters:
- WIDTH, 4, data word width.
- DEPTH, 2, shared FIFO entries (power of 2).
- NUM_FIFOS, 2, logical queues = producers = consumers.
- QUOTA, DEPTH, max entries any single queue may hold (1..DEPTH).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- enq_vld  in  NUM_FIFOS  producer q has a word for queue q
- enq_data  in  NUM_FIFOS*WIDTH  producer words; slice q = bits [q*WIDTH +: WIDTH]
- enq_rdy  out  NUM_FIFOS  one-hot grant, combinational; word q accepted when enq_vld[q] & enq_rdy[q]
- deq_rdy  in  NUM_FIFOS  consumer q can take a word this cycle
- out_vld  out  1  registered pulse: out_data is valid
- out_qid  out  SEL_WIDTH  queue id of out_data
- out_data  out  WIDTH  popped word
- fifo_push  out  1  to FIFO push
- fifo_push_sel  out  SEL_WIDTH  to FIFO push_sel
- fifo_data_in  out  WIDTH  to FIFO data_in
- fifo_pop  out  1  to FIFO pop
- fifo_pop_sel  out  SEL_WIDTH  to FIFO pop_sel
- fifo_full  in  1  from FIFO full
- fifo_data_out  in  WIDTH  FIFO head of the pop_sel queue, combinational, same cycle
- occ  out  NUM_FIFOS*(PTR_WIDTH+1)  per-queue occupancy (debug/property)

Behaviour:
- Widths: PTR_WIDTH = $clog2(DEPTH); SEL_WIDTH = max(1, $clog2(NUM_FIFOS)).
- Reset: occ all 0, push_rr = 0, pop_rr = 0, out_vld = 0, out_qid = 0, out_data = 0.
- Push eligibility: push_elig[q] = enq_vld[q] & !fifo_full & (occ[q] < QUOTA).
- Push grant: round-robin over push_elig, starting at push_rr. enq_rdy is one-hot or zero.
- Push drive: fifo_push = |enq_rdy; fifo_push_sel = granted q; fifo_data_in = enq_data slice q.
- Pop eligibility: pop_elig[q] = deq_rdy[q] & (occ[q] != 0). Uses registered occ, so a word pushed this cycle is never popped in the same cycle.
- Pop grant: round-robin over pop_elig, starting at pop_rr. fifo_pop = |grant; fifo_pop_sel = granted q.
- Output, next cycle after a pop: out_vld = 1, out_qid = granted q, out_data = fifo_data_out. One-cycle latency, no backpressure: deq_rdy is the consumer's promise to accept.
- RR pointers: on a grant to q, pointer <= (q+1) mod NUM_FIFOS. No grant: pointer holds.
- Occupancy: occ[q] <= occ[q] + (push to q) - (pop of q).
  - Simultaneous push and pop of the same queue nets to 0.
  - occ never exceeds QUOTA and never underflows.
- Full FIFO with simultaneous pop: push is still blocked (fifo_full is sampled before the pop frees an entry).
- Invariants:
  - sum(occ) <= DEPTH.
  - sum(occ) == DEPTH iff fifo_full.
  - Never pop an empty queue; never push while full.
- Reset mid-operation: all state clears the next cycle. In-flight out_vld is dropped. FIFO contents are discarded by the FIFO's own reset on the same rst.

Optional Feature:
LL_FIFO_SCHED_STRICT_Q0_EN
- Defined: queue 0 has strict priority on the pop side. If pop_elig[0], queue 0 is granted and pop_rr does not advance; otherwise round-robin among the rest. The push side is unchanged.
- Undefined: pure round-robin on both sides, as described above.

Decomposition:
- Package ll_fifo_pkg: PTR_WIDTH/SEL_WIDTH derivation functions, the occ slice-width constant, and a qid typedef helper.
- Sub-module rr_arbiter (params N; ports req[N], ptr, gnt[N] one-hot, gnt_idx), purely combinational. Instantiated twice, for push and pop.
- Pointer, occupancy and output registers live in ll_fifo_sched.

Test Plan:
Config WIDTH=4, DEPTH=4, NUM_FIFOS=2, QUOTA=3 unless noted.
1. Reset, then enq_vld=2'b11 held with data 0xA/0x5, deq_rdy=0 → grants alternate q0,q1,q0 (push_rr wraps). occ0 stops at 2 and occ1 at 2 once full; enq_rdy=0 while fifo_full.
2. Quota: only q0 pushes 0x1..0x4 → 3 accepted, 4th stalls with occ0=3 and fifo_full=0. Then q1 push is granted at once.
3. Pop RR: occ0=2, occ1=2, deq_rdy=2'b11 → pop order q0,q1,q0,q1. out_vld one cycle after each pop with the matching qid/data, FIFO order preserved per queue.
4. Same cycle: q1 push into empty q1 with deq_rdy[1]=1 → no pop that cycle. Pop next cycle, out_data = pushed value two cycles after the push.
5. fifo_full=1 with a pop → push still denied that cycle, granted the next cycle. occ stays consistent.
6. With LL_FIFO_SCHED_STRICT_Q0_EN: occ0=3, occ1=1, deq_rdy=2'b11 → three q0 pops, then q1. Also assert rst mid-burst → out_vld=0 and occ=0 the next cycle.
